multicycle_memory: RTL and testbench

//  Responder end of the CPU data-memory request interface (data_in/addr/enable/wr -> data_out).

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_array.sv | 20 ++
 rtl/multicycle_memory.sv | 115 +++++++++++
 tb/tb_multicycle_memory.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the multicycle data memory: FSM encoding and default geometry.
package mem_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word store, read-first; contents are never reset.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
    rdata <= mem_q[idx];
  end

endmodule

// File: rtl/multicycle_memory.sv
// Fixed-latency data-memory responder: accepts one request, stalls the initiator
// while busy, then pulses data_valid for one cycle when the access has completed.
module multicycle_memory
  import mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [15:0]       addr,
  input  logic              enable,
  input  logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              stall,
  output state_t            dbg_state
);

  localparam int CNT_W = $clog2(LATENCY);

  // Handshake: a request is taken on any edge where enable=1 and stall=0;
  // the initiator must hold it while stall=1 and sees completion as data_valid.
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q;
  logic              accept, execute;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_idx;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr;

  assign unused_addr = ^{addr[15:ADDR_W+1], addr[0]};

  assign accept  = enable && ((state_q == IDLE) || (state_q == RESP));
  assign execute = (state_q == BUSY) && (cnt_q == '0);
  // Steering the RAM to the incoming index on accept lets the read data settle
  // during BUSY, so it is ready at the commit edge even for LATENCY=2.
  assign ram_idx = accept ? addr[ADDR_W:1] : idx_q;
  assign ram_we  = execute && wr_q && !rst;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 2);
          idx_d   = addr[ADDR_W:1];
          wdata_d = data_in;
          wr_d    = wr;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (execute) begin
          state_d = RESP;
          if (!wr_q) data_out_d = ram_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= (state_d == RESP);
    end
  end

  mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .idx  (ram_idx),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign stall      = (state_q == BUSY);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_multicycle_memory.sv
// Directed bench for multicycle_memory: vector table of requests plus hand-written
// reset-during-access sequences.
module tb_multicycle_memory;
  import mem_pkg::*;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [15:0] addr;
  logic        enable;
  logic        wr;
  logic [15:0] data_out;
  logic        data_valid;
  logic        stall;
  state_t      dbg_state;

  int checks   = 0;
  int failures = 0;

  multicycle_memory #(.DATA_W(16), .ADDR_W(9), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .addr      (addr),
    .enable    (enable),
    .wr        (wr),
    .data_out  (data_out),
    .data_valid(data_valid),
    .stall     (stall),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;   // data_out in the completion cycle
    bit          scr;   // scramble inputs while stalled
    bit          b2b;   // next request issued in this one's RESP cycle
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Called at posedge+1 of the request cycle; returns at posedge+1 of the RESP cycle.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input bit prev_dv, input logic [15:0] prev_exp, input bit scr);
    enable = 1'b1; wr = w; addr = a; data_in = d;
    @(negedge clk);
    chk("accept_stall", 32'(stall), 32'd0);
    chk("resp_valid", 32'(data_valid), 32'(prev_dv));
    if (prev_dv) chk("resp_data", 32'(data_out), 32'(prev_exp));
    @(posedge clk); #1;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      chk("busy_stall", 32'(stall), 32'd1);
      chk("busy_valid", 32'(data_valid), 32'd0);
      chk("busy_state", 32'(dbg_state), 32'(BUSY));
      if (scr) begin
        addr    = 16'($urandom_range(0, 16'hffff));
        data_in = 16'($urandom_range(0, 16'hffff));
        wr      = 1'($urandom_range(0, 1));
        enable  = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    enable = 1'b0;
  endtask

  task automatic finish_req(input logic [15:0] exp);
    @(negedge clk);
    chk("done_valid", 32'(data_valid), 32'd1);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_data", 32'(data_out), 32'(exp));
    chk("done_state", 32'(dbg_state), 32'(RESP));
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_valid", 32'(data_valid), 32'd0);
    chk("after_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
  endtask

  // Write to 0x0020, then raise rst during cycle T+k (k counted from acceptance).
  task automatic reset_midop(input logic [15:0] d, input int k);
    enable = 1'b1; wr = 1'b1; addr = 16'h0020; data_in = d;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (k - 1) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      @(negedge clk);
      chk("rstmid_valid", 32'(data_valid), 32'd0);
      chk("rstmid_stall", 32'(stall), 32'd0);
      chk("rstmid_data", 32'(data_out), 32'd0);
      @(posedge clk); #1;
    end
    do_req(1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0, 1'b0);
    finish_req(16'hA5A5);
  endtask

  vec_t vecs[11];
  bit          prev_dv;
  logic [15:0] prev_exp;

  initial begin
    vecs[0]  = '{wr:1'b1, addr:16'h0010, data:16'hBEEF, exp:16'h0000, scr:1'b0, b2b:1'b0};
    vecs[1]  = '{wr:1'b0, addr:16'h0010, data:16'h0000, exp:16'hBEEF, scr:1'b0, b2b:1'b1};
    vecs[2]  = '{wr:1'b1, addr:16'h0402, data:16'h1234, exp:16'hBEEF, scr:1'b0, b2b:1'b1};
    vecs[3]  = '{wr:1'b0, addr:16'h0002, data:16'h0000, exp:16'h1234, scr:1'b0, b2b:1'b1};
    vecs[4]  = '{wr:1'b0, addr:16'h0003, data:16'h0000, exp:16'h1234, scr:1'b0, b2b:1'b0};
    vecs[5]  = '{wr:1'b1, addr:16'h0030, data:16'h1111, exp:16'h1234, scr:1'b1, b2b:1'b0};
    vecs[6]  = '{wr:1'b0, addr:16'h0030, data:16'h0000, exp:16'h1111, scr:1'b1, b2b:1'b0};
    vecs[7]  = '{wr:1'b1, addr:16'h0020, data:16'hA5A5, exp:16'h1111, scr:1'b0, b2b:1'b1};
    vecs[8]  = '{wr:1'b0, addr:16'h0020, data:16'h0000, exp:16'hA5A5, scr:1'b0, b2b:1'b0};
    vecs[9]  = '{wr:1'b1, addr:16'h1010, data:16'hCAFE, exp:16'hA5A5, scr:1'b0, b2b:1'b0};
    vecs[10] = '{wr:1'b0, addr:16'h0011, data:16'h0000, exp:16'hCAFE, scr:1'b0, b2b:1'b0};

    // reset held two cycles with a live write request on the bus
    rst = 1'b1; enable = 1'b1; wr = 1'b1; addr = 16'h0010; data_in = 16'hDEAD;
    repeat (2) begin
      @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_stall", 32'(stall), 32'd0);
      chk("post_rst_valid", 32'(data_valid), 32'd0);
      chk("post_rst_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk); #1;
    end

    prev_dv  = 1'b0;
    prev_exp = 16'h0;
    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].data, prev_dv, prev_exp, vecs[i].scr);
      if (vecs[i].b2b) begin
        prev_dv  = 1'b1;
        prev_exp = vecs[i].exp;
      end else begin
        finish_req(vecs[i].exp);
        prev_dv = 1'b0;
      end
    end

    reset_midop(16'h5555, 2);
    reset_midop(16'h6666, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
